usb_chan_fifo: RTL and testbench

- Parametrised multi-channel receive-side FIFO bank. It replaces the separate per-packet-class FIFOs (PID, non-data, CRC/pad, data) with one block.
- Written from the shared receive byte bus, with a one-hot channel write select driven by the PID decoder.
- Read by the transmit control unit through a single shared, registered read port with a channel select.
- Adds per-channel flush, overflow/underflow error flags and occupancy counts.

---
 rtl/usb_chan_fifo.sv | 170 +++++++++++++++++
 tb/tb_usb_chan_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_chan_fifo.sv
// Multi-channel receive FIFO bank: per-channel circular buffers, shared write
// bus, one registered read port. Optional almost_full: USB_CHAN_FIFO_AFULL_EN.
module usb_chan_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int NCH       = 4,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic [NCH-1:0]                       w_enable,
    input  logic [WIDTH-1:0]                     w_data,
    input  logic                                 r_enable,
    input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] r_sel,
    input  logic [NCH-1:0]                       flush,
    output logic [WIDTH-1:0]                     r_data,
    output logic                                 r_valid,
    output logic [NCH-1:0]                       empty,
    output logic [NCH-1:0]                       full,
    output logic [NCH-1:0]                       almost_full,
    output logic [NCH*$clog2(DEPTH+1)-1:0]       count,
    output logic [NCH-1:0]                       overflow,
    output logic [NCH-1:0]                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("usb_chan_fifo: DEPTH must be a power of 2, >= 2");
    end
    if (NCH < 1) begin : g_bad_nch
        $error("usb_chan_fifo: NCH must be >= 1");
    end
    if (AFULL_LVL < 0 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("usb_chan_fifo: AFULL_LVL out of range");
    end

    logic [WIDTH-1:0] r_mem [NCH][DEPTH];
    logic [PW-1:0]    r_wptr [NCH];
    logic [PW-1:0]    r_rptr [NCH];
    logic [CW-1:0]    r_cnt [NCH];
    logic [CW-1:0]    w_cnt_nxt [NCH];
    logic [NCH-1:0]   r_empty;
    logic [NCH-1:0]   r_full;
    logic [NCH-1:0]   r_ovf;
    logic [NCH-1:0]   r_udf;
    logic [NCH-1:0]   w_sel;
    logic [NCH-1:0]   w_rd_hit;
    logic [NCH-1:0]   w_rd_miss;
    logic [NCH-1:0]   w_wr_acc;
    logic [NCH-1:0]   w_wr_drop;
    logic [WIDTH-1:0] w_head;
    logic             w_rd_any;

    // Accept/drop decisions per channel; flush beats any access to its channel.
    always_comb begin
        w_sel     = '0;
        w_rd_hit  = '0;
        w_rd_miss = '0;
        w_wr_acc  = '0;
        w_wr_drop = '0;
        w_head    = '0;
        for (int k = 0; k < NCH; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
            w_sel[k]     = r_enable && (r_sel == SW'(k));
            w_rd_hit[k]  = w_sel[k] && !r_empty[k] && !flush[k];
            w_rd_miss[k] = w_sel[k] && r_empty[k] && !flush[k];
            w_wr_acc[k]  = w_enable[k] && !flush[k] && (!r_full[k] || w_rd_hit[k]);
            w_wr_drop[k] = w_enable[k] && !flush[k] && r_full[k] && !w_rd_hit[k];
            if (flush[k])
                w_cnt_nxt[k] = '0;
            else if (w_wr_acc[k] && !w_rd_hit[k])
                w_cnt_nxt[k] = r_cnt[k] + CW'(1);
            else if (!w_wr_acc[k] && w_rd_hit[k])
                w_cnt_nxt[k] = r_cnt[k] - CW'(1);
            if (w_rd_hit[k])
                w_head = r_mem[k][r_rptr[k]];
        end
        w_rd_any = |w_rd_hit;
    end

    // Per-channel pointers, occupancy, status and sticky error flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
                r_cnt[k]  <= '0;
            end
            r_empty <= '1;
            r_full  <= '0;
            r_ovf   <= '0;
            r_udf   <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                r_cnt[k]   <= w_cnt_nxt[k];
                r_empty[k] <= (w_cnt_nxt[k] == '0);
                r_full[k]  <= (w_cnt_nxt[k] == CW'(DEPTH));
                if (flush[k]) begin
                    r_wptr[k] <= '0;
                    r_rptr[k] <= '0;
                    r_ovf[k]  <= 1'b0;
                    r_udf[k]  <= 1'b0;
                end else begin
                    if (w_wr_acc[k])
                        r_wptr[k] <= r_wptr[k] + PW'(1);
                    if (w_rd_hit[k])
                        r_rptr[k] <= r_rptr[k] + PW'(1);
                    if (w_wr_drop[k])
                        r_ovf[k] <= 1'b1;
                    if (w_rd_miss[k])
                        r_udf[k] <= 1'b1;
                end
            end
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (w_wr_acc[k])
                r_mem[k][r_wptr[k]] <= w_data;
        end
    end

    // Registered shared read port; r_data holds on a dropped read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_any;
            if (w_rd_any)
                r_data <= w_head;
        end
    end

`ifdef USB_CHAN_FIFO_AFULL_EN
    logic [NCH-1:0] r_afull;

    // Almost-full tracks the next-state occupancy like empty/full.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_afull <= '0;
        end else begin
            for (int k = 0; k < NCH; k++)
                r_afull[k] <= (w_cnt_nxt[k] >= CW'(AFULL_LVL));
        end
    end

    assign almost_full = r_afull;
`else
    assign almost_full = '0;
`endif

    // Flatten per-channel occupancy onto the count bus.
    always_comb begin
        count = '0;
        for (int k = 0; k < NCH; k++)
            count[k*CW +: CW] = r_cnt[k];
    end

    assign empty     = r_empty;
    assign full      = r_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule

// File: tb/tb_usb_chan_fifo.sv
// Directed bench for usb_chan_fifo with hand-computed expectations.
// Default parameters: WIDTH 8, DEPTH 8, NCH 4.
module tb_usb_chan_fifo;

    localparam int CW = 4;

    logic         clk;
    logic         n_rst;
    logic [3:0]   w_enable;
    logic [7:0]   w_data;
    logic         r_enable;
    logic [1:0]   r_sel;
    logic [3:0]   flush;
    logic [7:0]   r_data;
    logic         r_valid;
    logic [3:0]   empty;
    logic [3:0]   full;
    logic [3:0]   almost_full;
    logic [15:0]  count;
    logic [3:0]   overflow;
    logic [3:0]   underflow;

    int n_chk;
    int n_err;

    usb_chan_fifo dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .w_enable    (w_enable),
        .w_data      (w_data),
        .r_enable    (r_enable),
        .r_sel       (r_sel),
        .flush       (flush),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int k);
        return count[k*CW +: CW];
    endfunction

    logic af_on;

    initial begin
        n_chk    = 0;
        n_err    = 0;
`ifdef USB_CHAN_FIFO_AFULL_EN
        af_on    = 1'b1;
`else
        af_on    = 1'b0;
`endif
        n_rst    = 1'b0;
        w_enable = '0;
        w_data   = '0;
        r_enable = 1'b0;
        r_sel    = '0;
        flush    = '0;
        #23;
        check("rst_empty", 32'(empty), 32'hF);
        check("rst_full", 32'(full), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_udf", 32'(underflow), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_valid", 32'(r_valid), 32'h0);
        check("rst_rdata", 32'(r_data), 32'h0);
        check("rst_afull", 32'(almost_full), 32'h0);
        n_rst = 1'b1;
        step();

        // Fill channel 2, then one extra write that must be dropped
        for (int i = 0; i < 8; i++) begin
            w_enable = 4'b0100;
            w_data   = 8'(8'h10 + i);
            step();
        end
        check("fill_full", 32'(full[2]), 32'h1);
        check("fill_ovf_pre", 32'(overflow[2]), 32'h0);
        w_data = 8'hAA;
        step();
        w_enable = '0;
        check("of_full", 32'(full[2]), 32'h1);
        check("of_ovf", 32'(overflow[2]), 32'h1);
        check("of_cnt", 32'(cnt_of(2)), 32'h8);
        r_enable = 1'b1;
        r_sel    = 2'd2;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rd2_data", 32'(r_data), 32'(8'h10 + i));
            check("rd2_valid", 32'(r_valid), 32'h1);
        end
        r_enable = 1'b0;
        step();
        check("rd2_idle", 32'(r_valid), 32'h0);
        check("rd2_empty", 32'(empty[2]), 32'h1);
        check("rd2_udf", 32'(underflow[2]), 32'h0);

        // Wrap-around on channel 0
        for (int r = 0; r < 3; r++) begin
            r_enable = 1'b0;
            for (int i = 0; i < 5; i++) begin
                w_enable = 4'b0001;
                w_data   = 8'(5 * r + i);
                step();
            end
            w_enable = '0;
            r_enable = 1'b1;
            r_sel    = 2'd0;
            for (int i = 0; i < 5; i++) begin
                step();
                check("wrap_data", 32'(r_data), 32'(5 * r + i));
            end
        end
        r_enable = 1'b0;
        step();
        check("wrap_empty", 32'(empty[0]), 32'h1);
        check("wrap_cnt", 32'(cnt_of(0)), 32'h0);

        // Channel 1 full with simultaneous read and write
        for (int i = 0; i < 8; i++) begin
            w_enable = 4'b0010;
            w_data   = 8'(8'h20 + i);
            step();
        end
        w_data   = 8'h55;
        r_enable = 1'b1;
        r_sel    = 2'd1;
        step();
        w_enable = '0;
        check("rw_data", 32'(r_data), 32'h20);
        check("rw_cnt", 32'(cnt_of(1)), 32'h8);
        check("rw_full", 32'(full[1]), 32'h1);
        check("rw_ovf", 32'(overflow[1]), 32'h0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("rw_drain", 32'(r_data), 32'(8'h20 + i));
        end
        step();
        check("rw_last", 32'(r_data), 32'h55);
        r_enable = 1'b0;
        step();
        check("rw_empty", 32'(empty[1]), 32'h1);

        // Read of empty channel 3 with a write in the same cycle
        w_enable = 4'b1000;
        w_data   = 8'h33;
        r_enable = 1'b1;
        r_sel    = 2'd3;
        step();
        w_enable = '0;
        check("ud_valid", 32'(r_valid), 32'h0);
        check("ud_hold", 32'(r_data), 32'h55);
        check("ud_udf", 32'(underflow[3]), 32'h1);
        check("ud_cnt", 32'(cnt_of(3)), 32'h1);
        step();
        r_enable = 1'b0;
        check("ud_data", 32'(r_data), 32'h33);
        check("ud_valid2", 32'(r_valid), 32'h1);

        // Broadcast, then flush channel 2 while reading it
        w_enable = 4'b0101;
        w_data   = 8'h77;
        step();
        w_enable = '0;
        check("bc_cnt0", 32'(cnt_of(0)), 32'h1);
        check("bc_cnt2", 32'(cnt_of(2)), 32'h1);
        flush    = 4'b0100;
        r_enable = 1'b1;
        r_sel    = 2'd2;
        step();
        flush    = '0;
        r_enable = 1'b0;
        check("fl_valid", 32'(r_valid), 32'h0);
        check("fl_empty", 32'(empty[2]), 32'h1);
        check("fl_cnt2", 32'(cnt_of(2)), 32'h0);
        check("fl_ovf", 32'(overflow[2]), 32'h0);
        check("fl_udf", 32'(underflow[2]), 32'h0);
        check("fl_cnt0", 32'(cnt_of(0)), 32'h1);
        check("fl_udf3", 32'(underflow[3]), 32'h1);
        r_enable = 1'b1;
        r_sel    = 2'd0;
        step();
        r_enable = 1'b0;
        check("bc_data0", 32'(r_data), 32'h77);

        // Almost-full on channel 0 at occupancy 6
        for (int i = 0; i < 6; i++) begin
            w_enable = 4'b0001;
            w_data   = 8'(i);
            step();
            if (i == 4)
                check("af_at5", 32'(almost_full[0]), 32'h0);
        end
        w_enable = '0;
        check("af_cnt", 32'(cnt_of(0)), 32'h6);
        check("af_at6", 32'(almost_full[0]), 32'(af_on));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
